// File: rtl/hoplite_rt_switch_if.sv
// Port bundle for one Hoplite torus switch: W/N link inputs, PE injection queue,
// E/S link outputs, PE ejection and status counters.
interface hoplite_rt_switch_if #(
  parameter int P_W   = 32,
  parameter int CNT_W = 3
);
  // pein is valid/ready: a push happens on a clock edge where pein_vld & pein_rdy;
  // the producer holds pkt stable while vld is high. Link and ejection ports are valid-only.
  logic [P_W-1:0]   xin_pkt;
  logic             xin_vld;
  logic [P_W-1:0]   yin_pkt;
  logic             yin_vld;
  logic [P_W-1:0]   pein_pkt;
  logic             pein_vld;
  logic             pein_rdy;
  logic [P_W-1:0]   xout_pkt;
  logic             xout_vld;
  logic [P_W-1:0]   yout_pkt;
  logic             yout_vld;
  logic [P_W-1:0]   peout_pkt;
  logic             peout_vld;
  logic [CNT_W-1:0] fifo_cnt;
  logic [15:0]      defl_cnt;

  modport master (
    output xin_pkt, xin_vld, yin_pkt, yin_vld, pein_pkt, pein_vld,
    input  pein_rdy, xout_pkt, xout_vld, yout_pkt, yout_vld,
    input  peout_pkt, peout_vld, fifo_cnt, defl_cnt
  );

  modport slave (
    input  xin_pkt, xin_vld, yin_pkt, yin_vld, pein_pkt, pein_vld,
    output pein_rdy, xout_pkt, xout_vld, yout_pkt, yout_vld,
    output peout_pkt, peout_vld, fifo_cnt, defl_cnt
  );
endinterface

// File: rtl/hoplite_rt_switch.sv
// Hoplite deflection-torus switch: X-then-Y bufferless routing (W > N > PE),
// queued PE injection regulated by a token bucket, registered ejection.
`ifndef HOPLITE_ADDR_MACROS
`define HOPLITE_ADDR_MACROS
`define ADDRX(p) p[X_AW-1:0]
`define ADDRY(p) p[X_AW+Y_AW-1:X_AW]
`endif

module hoplite_rt_switch #(
  parameter int P_W        = 32,
  parameter int X_AW       = 2,
  parameter int Y_AW       = 2,
  parameter int X_POS      = 0,
  parameter int Y_POS      = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int TB_EN      = 1,
  parameter int TB_PERIOD  = 8,
  parameter int TB_BURST   = 2,
  localparam int TKW       = $clog2(TB_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  hoplite_rt_switch_if.slave bus,
  output logic [TKW-1:0]     o_dbg_tokens
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMW   = (TB_PERIOD > 1) ? $clog2(TB_PERIOD) : 1;

  localparam logic [X_AW-1:0]  LP_X          = X_AW'(X_POS);
  localparam logic [Y_AW-1:0]  LP_Y          = Y_AW'(Y_POS);
  localparam logic [CNT_W-1:0] LP_DEPTH      = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LP_PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [TKW-1:0]   LP_BURST      = TKW'(TB_BURST);
  localparam logic [TMW-1:0]   LP_TIMER_LAST = TMW'(TB_PERIOD - 1);

  // Reset synchroniser: assertion is immediate, release lines up with clk.
  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic             r_run;

  logic [P_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [TKW-1:0]   r_tokens;
  logic [TMW-1:0]   r_timer;

  logic [P_W-1:0]   r_xout_pkt;
  logic             r_xout_vld;
  logic [P_W-1:0]   r_yout_pkt;
  logic             r_yout_vld;
  logic [P_W-1:0]   r_peout_pkt;
  logic             r_peout_vld;
  logic [15:0]      r_defl_cnt;

  logic [P_W-1:0]   w_head;
  logic             w_w_east;
  logic             w_w_south;
  logic             w_n_defl;
  logic             w_n_south;
  logic             w_head_ok;
  logic             w_head_east;
  logic             w_inj_e;
  logic             w_inj_s;
  logic             w_pop;
  logic             w_push;
  logic             w_e_vld;
  logic [P_W-1:0]   w_e_pkt;
  logic             w_s_vld;
  logic [P_W-1:0]   w_s_pkt;
  logic             w_eject;
  logic             w_refill;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LP_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_head   = r_mem[r_rd_ptr];
  assign w_push   = bus.pein_vld && bus.pein_rdy;
  assign w_refill = (r_timer == LP_TIMER_LAST);

  // Route decision: W first, N takes S unless W turned, PE fills whatever is left.
  always_comb begin
    w_w_east    = bus.xin_vld && (`ADDRX(bus.xin_pkt) != LP_X);
    w_w_south   = bus.xin_vld && (`ADDRX(bus.xin_pkt) == LP_X);
    w_n_defl    = bus.yin_vld && w_w_south;
    w_n_south   = bus.yin_vld && !w_w_south;
    w_head_ok   = (r_cnt != '0) && ((TB_EN == 0) || (r_tokens != '0));
    w_head_east = (`ADDRX(w_head) != LP_X);
    w_inj_e     = w_head_ok && w_head_east && !w_w_east && !w_n_defl;
    w_inj_s     = w_head_ok && !w_head_east && !w_w_south && !w_n_south;
    w_pop       = w_inj_e || w_inj_s;

    w_e_vld = w_w_east || w_n_defl || w_inj_e;
    w_e_pkt = '0;
    if (w_w_east)      w_e_pkt = bus.xin_pkt;
    else if (w_n_defl) w_e_pkt = bus.yin_pkt;
    else if (w_inj_e)  w_e_pkt = w_head;

    w_s_vld = w_w_south || w_n_south || w_inj_s;
    w_s_pkt = '0;
    if (w_w_south)      w_s_pkt = bus.xin_pkt;
    else if (w_n_south) w_s_pkt = bus.yin_pkt;
    else if (w_inj_s)   w_s_pkt = w_head;

    // A self-addressed PE packet rides the Y ring instead of ejecting here.
    w_eject = (w_w_south || w_n_south) && (`ADDRY(w_s_pkt) == LP_Y);
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_run       <= 1'b0;
      r_xout_pkt  <= '0;
      r_xout_vld  <= 1'b0;
      r_yout_pkt  <= '0;
      r_yout_vld  <= 1'b0;
      r_peout_pkt <= '0;
      r_peout_vld <= 1'b0;
      r_defl_cnt  <= '0;
    end else begin
      r_run       <= 1'b1;
      r_xout_pkt  <= w_e_pkt;
      r_xout_vld  <= w_e_vld;
      r_yout_pkt  <= w_s_pkt;
      r_yout_vld  <= w_s_vld && !w_eject;
      r_peout_pkt <= w_eject ? w_s_pkt : '0;
      r_peout_vld <= w_eject;
      if (w_n_defl && (r_defl_cnt != 16'hFFFF)) r_defl_cnt <= r_defl_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.pein_pkt;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Token bucket: a refill and a spend in the same cycle cancel out.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tokens <= LP_BURST;
      r_timer  <= '0;
    end else if (TB_EN != 0) begin
      r_timer <= w_refill ? '0 : r_timer + 1'b1;
      if (w_refill && !w_pop) begin
        if (r_tokens < LP_BURST) r_tokens <= r_tokens + 1'b1;
      end else if (!w_refill && w_pop) begin
        r_tokens <= r_tokens - 1'b1;
      end
    end
  end

  assign bus.pein_rdy  = r_run && (r_cnt < LP_DEPTH);
  assign bus.xout_pkt  = r_xout_pkt;
  assign bus.xout_vld  = r_xout_vld;
  assign bus.yout_pkt  = r_yout_pkt;
  assign bus.yout_vld  = r_yout_vld;
  assign bus.peout_pkt = r_peout_pkt;
  assign bus.peout_vld = r_peout_vld;
  assign bus.fifo_cnt  = r_cnt;
  assign bus.defl_cnt  = r_defl_cnt;
  assign o_dbg_tokens  = r_tokens;

endmodule

// File: tb/tb_hoplite_rt_switch.sv
// Directed bench for hoplite_rt_switch at node (1,1): routing vector table plus
// sequences for queueing, reset, token-bucket pacing and PE hold-off.
module tb_hoplite_rt_switch;

  logic       clk;
  logic       rst_n;
  logic [1:0] tok_a;
  logic [1:0] tok_b;

  int n_tests;
  int n_fail;
  int cyc;

  logic [31:0] exp_q[$];
  int          ta[$];
  logic [31:0] pa[$];
  int          tb_t[$];
  logic [31:0] tb_p[$];
  bit          mon_a;
  bit          mon_b;

  typedef struct {
    logic        xv;
    logic [31:0] xp;
    logic        yv;
    logic [31:0] yp;
    logic        exv;
    logic [31:0] ex;
    logic        eyv;
    logic [31:0] ey;
    logic        epv;
    logic [31:0] ep;
    int          dinc;
  } vec_t;

  vec_t vecs[11];

  hoplite_rt_switch_if #(.P_W(32), .CNT_W(3)) bus ();
  hoplite_rt_switch_if #(.P_W(32), .CNT_W(3)) bus0 ();

  hoplite_rt_switch #(
    .P_W(32), .X_AW(2), .Y_AW(2), .X_POS(1), .Y_POS(1), .FIFO_DEPTH(4),
    .TB_EN(1), .TB_PERIOD(8), .TB_BURST(2)
  ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_tokens(tok_a));

  hoplite_rt_switch #(
    .P_W(32), .X_AW(2), .Y_AW(2), .X_POS(1), .Y_POS(1), .FIFO_DEPTH(4),
    .TB_EN(0), .TB_PERIOD(8), .TB_BURST(2)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .o_dbg_tokens(tok_b));

  // clock / cycle count / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (mon_a && bus.xout_vld) begin
      ta.push_back(cyc);
      pa.push_back(bus.xout_pkt);
    end
    if (mon_b && bus0.xout_vld) begin
      tb_t.push_back(cyc);
      tb_p.push_back(bus0.xout_pkt);
    end
  end

  function automatic logic [31:0] mk(input int x, input int y, input int pl);
    return {pl[27:0], y[1:0], x[1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.xin_vld   = 1'b0;  bus.xin_pkt  = '0;
    bus.yin_vld   = 1'b0;  bus.yin_pkt  = '0;
    bus.pein_vld  = 1'b0;  bus.pein_pkt = '0;
    bus0.xin_vld  = 1'b0;  bus0.xin_pkt = '0;
    bus0.yin_vld  = 1'b0;  bus0.yin_pkt = '0;
    bus0.pein_vld = 1'b0;  bus0.pein_pkt = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  // driver: push one packet, waiting a bounded time for ready
  task automatic push_one(input bit sel, input logic [31:0] pkt);
    logic ok;
    ok = 1'b0;
    if (sel) begin bus0.pein_pkt = pkt; bus0.pein_vld = 1'b1; end
    else     begin bus.pein_pkt  = pkt; bus.pein_vld  = 1'b1; end
    for (int i = 0; i < 100; i++) begin
      ok = sel ? bus0.pein_rdy : bus.pein_rdy;
      tick();
      if (ok) break;
    end
    check("push_accepted", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic [31:0] w_pkt;
    logic [31:0] p_pkt;
    logic [31:0] s_pkt;
    logic [31:0] n1;
    logic [31:0] n2;
    int          exp_defl;
    int          g;
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    mon_a    = 1'b0;
    mon_b    = 1'b0;
    exp_defl = 0;
    rst_n    = 1'b0;
    idle_inputs();

    // reset state
    repeat (2) tick();
    check("rst_pein_rdy_low", {31'd0, bus.pein_rdy}, 32'd0);
    check("rst_xout_vld",     {31'd0, bus.xout_vld}, 32'd0);
    check("rst_yout_vld",     {31'd0, bus.yout_vld}, 32'd0);
    check("rst_peout_vld",    {31'd0, bus.peout_vld}, 32'd0);
    check("rst_xout_pkt",     bus.xout_pkt, 32'd0);
    check("rst_yout_pkt",     bus.yout_pkt, 32'd0);
    check("rst_peout_pkt",    bus.peout_pkt, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("rst_fifo_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
    check("rst_defl_cnt", {16'd0, bus.defl_cnt}, 32'd0);
    check("rst_tokens",   {30'd0, tok_a}, 32'd2);
    check("rst_pein_rdy", {31'd0, bus.pein_rdy}, 32'd1);

    // routing table at node (1,1), PE queue empty
    vecs[0]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 0};
    vecs[1]  = '{1'b1, mk(2,0,'h11), 1'b0, 32'd0, 1'b1, mk(2,0,'h11), 1'b0, 32'd0, 1'b0, 32'd0, 0};
    vecs[2]  = '{1'b1, mk(1,2,'h12), 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, mk(1,2,'h12), 1'b0, 32'd0, 0};
    vecs[3]  = '{1'b1, mk(1,1,'h13), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, mk(1,1,'h13), 0};
    vecs[4]  = '{1'b0, 32'd0, 1'b1, mk(0,3,'h14), 1'b0, 32'd0, 1'b1, mk(0,3,'h14), 1'b0, 32'd0, 0};
    vecs[5]  = '{1'b0, 32'd0, 1'b1, mk(2,1,'h15), 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, mk(2,1,'h15), 0};
    vecs[6]  = '{1'b1, mk(1,2,'h16), 1'b1, mk(0,3,'h17), 1'b1, mk(0,3,'h17), 1'b1, mk(1,2,'h16), 1'b0, 32'd0, 1};
    vecs[7]  = '{1'b1, mk(3,1,'h18), 1'b1, mk(1,1,'h19), 1'b1, mk(3,1,'h18), 1'b0, 32'd0, 1'b1, mk(1,1,'h19), 0};
    vecs[8]  = '{1'b1, mk(1,1,'h1a), 1'b1, mk(2,2,'h1b), 1'b1, mk(2,2,'h1b), 1'b0, 32'd0, 1'b1, mk(1,1,'h1a), 1};
    vecs[9]  = '{1'b1, mk(0,0,'h1c), 1'b1, mk(3,2,'h1d), 1'b1, mk(0,0,'h1c), 1'b1, mk(3,2,'h1d), 1'b0, 32'd0, 0};
    vecs[10] = '{1'b1, mk(1,0,'h1e), 1'b1, mk(0,0,'h1f), 1'b1, mk(0,0,'h1f), 1'b1, mk(1,0,'h1e), 1'b0, 32'd0, 1};

    for (int i = 0; i < 11; i++) begin
      bus.xin_vld = vecs[i].xv;  bus.xin_pkt = vecs[i].xp;
      bus.yin_vld = vecs[i].yv;  bus.yin_pkt = vecs[i].yp;
      exp_defl += vecs[i].dinc;
      tick();
      check($sformatf("vec%0d_xout_vld", i), {31'd0, bus.xout_vld}, {31'd0, vecs[i].exv});
      if (vecs[i].exv) check($sformatf("vec%0d_xout_pkt", i), bus.xout_pkt, vecs[i].ex);
      check($sformatf("vec%0d_yout_vld", i), {31'd0, bus.yout_vld}, {31'd0, vecs[i].eyv});
      if (vecs[i].eyv) check($sformatf("vec%0d_yout_pkt", i), bus.yout_pkt, vecs[i].ey);
      check($sformatf("vec%0d_peout_vld", i), {31'd0, bus.peout_vld}, {31'd0, vecs[i].epv});
      if (vecs[i].epv) check($sformatf("vec%0d_peout_pkt", i), bus.peout_pkt, vecs[i].ep);
      check($sformatf("vec%0d_defl_cnt", i), {16'd0, bus.defl_cnt}, exp_defl);
    end
    idle_inputs();
    tick();

    // reset mid-operation with three packets queued behind E-bound W traffic
    w_pkt = mk(2,0,'h30);
    bus.xin_pkt = w_pkt;
    bus.xin_vld = 1'b1;
    for (int i = 0; i < 3; i++) push_one(1'b0, mk(0,2,'h31 + i));
    bus.pein_vld = 1'b0;
    check("t1_fifo_cnt_before", {29'd0, bus.fifo_cnt}, 32'd3);
    check("t1_xout_vld_before", {31'd0, bus.xout_vld}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_async_xout_vld", {31'd0, bus.xout_vld}, 32'd0);
    check("t1_async_xout_pkt", bus.xout_pkt, 32'd0);
    check("t1_async_fifo_cnt", {29'd0, bus.fifo_cnt}, 32'd0);
    check("t1_async_defl_cnt", {16'd0, bus.defl_cnt}, 32'd0);
    check("t1_async_pein_rdy", {31'd0, bus.pein_rdy}, 32'd0);
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("t1_post_fifo_cnt",  {29'd0, bus.fifo_cnt}, 32'd0);
    check("t1_post_tokens",    {30'd0, tok_a}, 32'd2);
    check("t1_post_xout_vld",  {31'd0, bus.xout_vld}, 32'd0);
    check("t1_post_peout_vld", {31'd0, bus.peout_vld}, 32'd0);
    check("t1_post_pein_rdy",  {31'd0, bus.pein_rdy}, 32'd1);

    // PE held off S by N traffic, injects once N goes idle; self-addressed head stays on ring
    do_reset();
    p_pkt = mk(1,3,'h70);
    n1    = mk(0,2,'h71);
    n2    = mk(3,0,'h72);
    bus.pein_pkt = p_pkt;  bus.pein_vld = 1'b1;
    bus.yin_pkt  = n1;     bus.yin_vld  = 1'b1;
    tick();
    check("t6_yout_n1",  bus.yout_pkt, n1);
    check("t6_cnt_push", {29'd0, bus.fifo_cnt}, 32'd1);
    bus.pein_vld = 1'b0;
    bus.yin_pkt  = n2;
    tick();
    check("t6_yout_vld_n2", {31'd0, bus.yout_vld}, 32'd1);
    check("t6_yout_n2",     bus.yout_pkt, n2);
    check("t6_cnt_held",    {29'd0, bus.fifo_cnt}, 32'd1);
    check("t6_xout_idle",   {31'd0, bus.xout_vld}, 32'd0);
    bus.yin_vld = 1'b0;
    tick();
    check("t6_yout_vld_pe", {31'd0, bus.yout_vld}, 32'd1);
    check("t6_yout_pe",     bus.yout_pkt, p_pkt);
    check("t6_cnt_pop",     {29'd0, bus.fifo_cnt}, 32'd0);
    s_pkt = mk(1,1,'h73);
    push_one(1'b0, s_pkt);
    bus.pein_vld = 1'b0;
    tick();
    check("t6_self_yout_vld",  {31'd0, bus.yout_vld}, 32'd1);
    check("t6_self_yout_pkt",  bus.yout_pkt, s_pkt);
    check("t6_self_peout_vld", {31'd0, bus.peout_vld}, 32'd0);

    // queue fill with E blocked, refused push while full, then FIFO-order drain
    do_reset();
    exp_q.delete();
    w_pkt = mk(2,3,'h40);
    bus.xin_pkt  = w_pkt;
    bus.xin_vld  = 1'b1;
    bus.pein_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.pein_pkt = mk(0,1,'h60 + k);
      check($sformatf("t4_rdy%0d", k), {31'd0, bus.pein_rdy}, (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) exp_q.push_back(mk(0,1,'h60 + k));
      tick();
    end
    check("t4_cnt_full", {29'd0, bus.fifo_cnt}, 32'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_blocked_xout", bus.xout_pkt, w_pkt);
      check("t4_blocked_cnt",  {29'd0, bus.fifo_cnt}, 32'd4);
    end
    bus.xin_vld = 1'b0;
    check("t4_rdy_full", {31'd0, bus.pein_rdy}, 32'd0);
    tick();
    check("t4_cnt_pop_no_push", {29'd0, bus.fifo_cnt}, 32'd3);
    check("t4_first_vld",       {31'd0, bus.xout_vld}, 32'd1);
    check("t4_first_pkt",       bus.xout_pkt, exp_q.pop_front());
    bus.pein_vld = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      tick();
      if (bus.xout_vld) check("t4_drain_pkt", bus.xout_pkt, exp_q.pop_front());
    end
    check("t4_drain_left",  exp_q.size(), 32'd0);
    check("t4_drain_cnt",   {29'd0, bus.fifo_cnt}, 32'd0);
    repeat (10) tick();
    check("t4_no_extra",    {31'd0, bus.xout_vld}, 32'd0);

    // token-bucket pacing on u_dut, unregulated injection on u_dut0
    do_reset();
    ta.delete();
    pa.delete();
    mon_a = 1'b1;
    for (int i = 0; i < 6; i++) push_one(1'b0, mk(0,2,'h50 + i));
    bus.pein_vld = 1'b0;
    for (int k = 0; k < 80 && ta.size() < 6; k++) tick();
    repeat (10) tick();
    mon_a = 1'b0;
    check("t5a_count", ta.size(), 32'd6);
    for (int i = 0; i < ta.size() && i < 6; i++)
      check($sformatf("t5a_order%0d", i), pa[i], mk(0,2,'h50 + i));
    if (ta.size() >= 6) begin
      check("t5a_gap01", ta[1] - ta[0], 32'd1);
      g = ta[2] - ta[1];
      check("t5a_gap12_in_range", {31'd0, (g >= 1) && (g <= 8)}, 32'd1);
      check("t5a_gap34", ta[4] - ta[3], 32'd8);
      check("t5a_gap45", ta[5] - ta[4], 32'd8);
    end

    tb_t.delete();
    tb_p.delete();
    mon_b = 1'b1;
    for (int i = 0; i < 6; i++) push_one(1'b1, mk(0,2,'h58 + i));
    bus0.pein_vld = 1'b0;
    for (int k = 0; k < 40 && tb_t.size() < 6; k++) tick();
    repeat (5) tick();
    mon_b = 1'b0;
    check("t5b_count", tb_t.size(), 32'd6);
    for (int i = 0; i < tb_t.size() && i < 6; i++)
      check($sformatf("t5b_order%0d", i), tb_p[i], mk(0,2,'h58 + i));
    for (int i = 1; i < tb_t.size() && i < 6; i++)
      check($sformatf("t5b_gap%0d", i), tb_t[i] - tb_t[i-1], 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
